// File: rtl/snd_pkg.sv
// Shared types for the sample voice scheduler.
// State encoding, voice record and default tick divider.
package snd_pkg;
  localparam int SND_AW  = 14;
  localparam int SND_DIV = 2178;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_MIX
  } state_t;

  typedef struct packed {
    logic              active;
    logic [SND_AW-1:0] addr;
    logic [SND_AW-1:0] remain;
    logic [7:0]        sample;
  } voice_t;
endpackage

// File: rtl/snd_prescaler.sv
// Free-running sample-rate divider.
// Emits a one-cycle tick every DIV clocks.
module snd_prescaler
  import snd_pkg::*;
#(
  parameter int DIV = SND_DIV
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/sample_voice_scheduler.sv
// Time-shares one sample ROM port among VOICES playback voices
// and mixes the fetched bytes into a left-aligned 16-bit word.
module sample_voice_scheduler
  import snd_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int AW     = SND_AW,
  parameter int DIV    = SND_DIV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig_valid,
  output logic              trig_ready,
  input  logic [AW-1:0]     trig_addr,
  input  logic [AW-1:0]     trig_len,
  input  logic              stop_all,
  output logic [AW-1:0]     rom_a,
  input  logic [7:0]        rom_d,
  output logic [15:0]       audio_out,
  output logic              sample_strobe,
  output logic [VOICES-1:0] voice_busy
);
  localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int SH = 8 - $clog2(VOICES);
  localparam logic [IW-1:0] LASTI = IW'(VOICES - 1);

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_idx;
  voice_t        r_v [VOICES];
  logic [AW-1:0] r_rom_a;
  logic [15:0]   r_audio;
  logic          r_strobe;

  logic          w_tick;
  logic          w_free_any;
  logic [IW-1:0] w_free_idx;
  logic          w_accept;
  voice_t        w_cur;
  logic [15:0]   w_sum;
  logic [15:0]   w_mix;

  snd_prescaler #(.DIV(DIV)) u_presc (
    .i_clk  (clk),
    .i_reset(reset),
    .o_tick (w_tick)
  );

  // descending scan so the lowest free index wins
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (!r_v[v].active) begin
        w_free_any = 1'b1;
        w_free_idx = IW'(v);
      end
    end
  end

  assign trig_ready = (r_state == S_IDLE) &&
                      (w_free_any || (trig_len == '0));
  assign w_accept   = trig_valid && trig_ready &&
                      (trig_len != '0);
  assign w_cur      = r_v[r_idx];

  // address is combinational in READ so data lands in CAPTURE
  assign rom_a = (r_state == S_READ && w_cur.active) ?
                 w_cur.addr : r_rom_a;

  always_comb begin
    w_sum = '0;
    for (int v = 0; v < VOICES; v++) begin
      w_sum = w_sum + 16'(r_v[v].sample);
    end
    w_mix = w_sum << SH;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_tick) w_next = S_READ;
      S_READ:    w_next = S_CAPTURE;
      S_CAPTURE: w_next = (r_idx == LASTI) ? S_MIX : S_READ;
      S_MIX:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_rom_a  <= '0;
      r_audio  <= '0;
      r_strobe <= 1'b0;
      for (int v = 0; v < VOICES; v++) begin
        r_v[v] <= '0;
      end
    end else begin
      r_state  <= w_next;
      r_strobe <= (r_state == S_MIX);
      if (r_state == S_IDLE) begin
        r_idx <= '0;
      end else if (r_state == S_CAPTURE) begin
        r_idx <= r_idx + 1'b1;
      end
      if (r_state == S_READ) begin
        r_rom_a <= rom_a;
      end
      if (r_state == S_MIX) begin
        r_audio <= w_mix;
      end
      if (stop_all) begin
        for (int v = 0; v < VOICES; v++) begin
          r_v[v] <= '0;
        end
      end else begin
        if (w_accept) begin
          r_v[w_free_idx].active <= 1'b1;
          r_v[w_free_idx].addr   <= trig_addr;
          r_v[w_free_idx].remain <= trig_len;
        end
        if (r_state == S_CAPTURE) begin
          if (w_cur.active) begin
            r_v[r_idx].sample <= rom_d;
            r_v[r_idx].addr   <= w_cur.addr + 1'b1;
            r_v[r_idx].remain <= w_cur.remain - 1'b1;
            if (w_cur.remain == SND_AW'(1)) begin
              r_v[r_idx].active <= 1'b0;
            end
          end else begin
            r_v[r_idx].sample <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      voice_busy[v] = r_v[v].active;
    end
  end

  assign audio_out     = r_audio;
  assign sample_strobe = r_strobe;
endmodule
